// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: captures writeback retirements into a FIFO drained
// over a valid/ready port, with per-thread retire counters and drop tracking.

// One per-thread retire counter; wraps naturally at 2^CNT_WIDTH.
module retire_cnt_lane #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // clear wins over an increment arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end
endmodule

module retire_trace_buf #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS   = 4,
  parameter int DEPTH         = 16,
  parameter int CAPTURE_ALL   = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           retire_valid,
  input  logic                           reg_write_w,
  input  logic [4:0]                     rd_w,
  input  logic [DATA_WIDTH-1:0]          result_w,
  input  logic [$clog2(NUM_THREADS)-1:0] tid_w,
  input  logic [ADDRESS_WIDTH-1:0]       pc_w,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [$clog2(NUM_THREADS)-1:0] trace_tid,
  output logic [ADDRESS_WIDTH-1:0]       trace_pc,
  output logic [4:0]                     trace_rd,
  output logic                           trace_we,
  output logic [DATA_WIDTH-1:0]          trace_data,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           overflow,
  output logic [CNT_WIDTH-1:0]           drop_count,
  input  logic [$clog2(NUM_THREADS)-1:0] cnt_tid,
  output logic [CNT_WIDTH-1:0]           cnt_value
);
  localparam int TW = $clog2(NUM_THREADS);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [TW-1:0]            tid;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [4:0]               rd;
    logic                     we;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          we_eff, cap, pop, push, drop, full;

  logic [NUM_THREADS-1:0]                inc_vec;
  logic [NUM_THREADS-1:0][CNT_WIDTH-1:0] cnt_arr;

  assign we_eff      = reg_write_w && (rd_w != 5'd0);
  assign cap         = retire_valid && ((CAPTURE_ALL != 0) || we_eff);
  assign trace_valid = (fifo_count != '0);
  assign full        = (fifo_count == FULL_CNT);
  assign pop         = trace_valid && trace_ready;
  // a pop frees the slot this cycle, so a full FIFO can still accept
  assign push        = cap && (!full || pop);
  assign drop        = cap && full && !pop;

  // Pointers, occupancy and drop bookkeeping; clear overrides all traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  // Entry storage; not reset since head outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!clear && push)
      mem[wr_ptr] <= '{tid: tid_w, pc: pc_w, rd: rd_w, we: we_eff, data: result_w};
  end

  // Head is forced to zero when empty so stale or uninitialised slots never show.
  always_comb begin
    head = '0;
    if (trace_valid) head = mem[rd_ptr];
  end

  assign trace_tid  = head.tid;
  assign trace_pc   = head.pc;
  assign trace_rd   = head.rd;
  assign trace_we   = head.we;
  assign trace_data = head.data;

  // Per-thread counters count every retirement, regardless of capture or space.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    assign inc_vec[t] = retire_valid && (tid_w == TW'(t));
    retire_cnt_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (inc_vec[t]),
      .cnt   (cnt_arr[t])
    );
  end

  assign cnt_value = cnt_arr[cnt_tid];
endmodule

// File: tb/tb_retire_trace_buf.sv
// Scoreboard bench for retire_trace_buf: a capture-all instance (a) and a
// write-only capture instance (b) share every input.
module tb_retire_trace_buf;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, clear, retire_valid, reg_write_w, trace_ready;
  logic [4:0]  rd_w;
  logic [31:0] result_w, pc_w;
  logic [1:0]  tid_w, cnt_tid;

  logic        trace_valid, trace_we, overflow;
  logic [1:0]  trace_tid;
  logic [31:0] trace_pc, trace_data, drop_count, cnt_value;
  logic [4:0]  trace_rd, fifo_count;

  logic        b_valid, b_we, b_ovf;
  logic [1:0]  b_tid;
  logic [31:0] b_pc, b_data, b_drop, b_cnt;
  logic [4:0]  b_rd, b_count;

  typedef struct packed {
    logic [1:0]  tid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } ent_t;

  ent_t        head;
  ent_t        q[$];
  int unsigned m_cnt[4];
  int unsigned m_drop;
  bit          m_ovf;
  int          mb;
  int          n_vec = 0, n_err = 0;

  assign head = {trace_tid, trace_pc, trace_rd, trace_we, trace_data};

  always #5 clk = ~clk;

  retire_trace_buf #(.CAPTURE_ALL(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .retire_valid(retire_valid),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .tid_w(tid_w),
    .pc_w(pc_w), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_tid(trace_tid), .trace_pc(trace_pc), .trace_rd(trace_rd),
    .trace_we(trace_we), .trace_data(trace_data), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count), .cnt_tid(cnt_tid),
    .cnt_value(cnt_value));

  retire_trace_buf #(.CAPTURE_ALL(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .retire_valid(retire_valid),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .tid_w(tid_w),
    .pc_w(pc_w), .trace_valid(b_valid), .trace_ready(trace_ready),
    .trace_tid(b_tid), .trace_pc(b_pc), .trace_rd(b_rd),
    .trace_we(b_we), .trace_data(b_data), .fifo_count(b_count),
    .overflow(b_ovf), .drop_count(b_drop), .cnt_tid(cnt_tid),
    .cnt_value(b_cnt));

  task automatic model_reset();
    q.delete();
    mb = 0; m_drop = 0; m_ovf = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  // Advance the reference model with the inputs currently driven, then clock.
  task automatic tick();
    bit we, pop, pop2;
    if (rst || clear) model_reset();
    else begin
      we   = reg_write_w && (rd_w != 5'd0);
      pop  = (q.size() != 0) && trace_ready;
      pop2 = (mb != 0) && trace_ready;
      if (retire_valid) m_cnt[tid_w]++;
      if (pop) void'(q.pop_front());
      if (retire_valid) begin
        if (q.size() < DEPTH) q.push_back('{tid_w, pc_w, rd_w, we, result_w});
        else begin
          m_ovf = 1;
          if (m_drop != 32'hffff_ffff) m_drop++;
        end
      end
      if (pop2) mb--;
      if (retire_valid && we && mb < DEPTH) mb++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] pc, input logic [4:0] rd,
                       input logic w, input logic [31:0] d);
    retire_valid = 1; tid_w = t; pc_w = pc; rd_w = rd; reg_write_w = w; result_w = d;
  endtask

  task automatic test_reset();
    rst = 1; clear = 0; retire_valid = 0; reg_write_w = 0; rd_w = 0; result_w = 0;
    tid_w = 0; pc_w = 0; trace_ready = 0; cnt_tid = 0;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if ({trace_valid, fifo_count, overflow, drop_count} !== '0)
      $display("FAIL reset_state: valid=%b count=%0d ovf=%b drop=%0d, want all 0",
               trace_valid, fifo_count, overflow, drop_count);
    n_vec++;
    if ({trace_tid, trace_pc, trace_rd, trace_we, trace_data} !== '0) begin
      n_err++; $display("FAIL reset_head: got %h want 0", head);
    end
    for (int t = 0; t < 4; t++) begin
      cnt_tid = 2'(t); #1;
      n_vec++;
      if (cnt_value !== 0 || b_cnt !== 0) begin
        n_err++; $display("FAIL reset_cnt tid%0d: got %0d/%0d want 0", t, cnt_value, b_cnt);
      end
    end
    if ({trace_valid, fifo_count, overflow, drop_count} !== '0) n_err++;
  endtask

  task automatic test_round_robin();
    int popped = 0;
    trace_ready = 1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(2'(i % 4), 32'((i / 4) * 4), 5'd5, 1'b1, 32'((i % 4) * 16));
      else retire_valid = 0;
      n_vec++;
      if (trace_valid !== (q.size() != 0) || (i > 0 && fifo_count !== 5'd1)) begin
        n_err++; $display("FAIL rr_valid cyc%0d: valid=%b count=%0d want valid=%b count=1",
                          i, trace_valid, fifo_count, q.size() != 0);
      end else if (trace_valid) begin
        popped++;
        if (head !== q[0]) begin
          n_err++; $display("FAIL rr_head cyc%0d: got %h want %h", i, head, q[0]);
        end
      end
      tick();
    end
    n_vec++;
    if (popped !== 8 || trace_valid !== 1'b0) begin
      n_err++; $display("FAIL rr_popped: got %0d valid=%b want 8 valid=0", popped, trace_valid);
    end
    for (int t = 0; t < 4; t++) begin
      cnt_tid = 2'(t); #1;
      n_vec++;
      if (cnt_value !== 2 || b_cnt !== 2 || m_cnt[t] != 2) begin
        n_err++; $display("FAIL rr_cnt tid%0d: got %0d/%0d want 2", t, cnt_value, b_cnt);
      end
    end
  endtask

  task automatic test_x0_filter();
    trace_ready = 1;
    drive(2'd1, 32'h40, 5'd0, 1'b1, 32'haa);
    tick();
    drive(2'd1, 32'h44, 5'd7, 1'b0, 32'hbb);
    n_vec++;
    if (trace_valid !== 1'b1 || trace_we !== 1'b0 || head !== q[0]) begin
      n_err++; $display("FAIL x0_capture: valid=%b head=%h want we=0 head=%h",
                        trace_valid, head, q.size() ? q[0] : ent_t'(0));
    end
    n_vec++;
    if (b_count !== 0) begin
      n_err++; $display("FAIL x0_filtered: b count=%0d want 0", b_count);
    end
    tick();
    drive(2'd1, 32'h48, 5'd3, 1'b1, 32'hcc);
    n_vec++;
    if (trace_we !== 1'b0 || head !== q[0] || b_count !== 0) begin
      n_err++; $display("FAIL nowrite_capture: head=%h b_count=%0d want %h/0", head, b_count, q[0]);
    end
    tick();
    retire_valid = 0;
    n_vec++;
    if (b_count !== 5'd1 || b_rd !== 5'd3 || b_data !== 32'hcc || b_we !== 1'b1) begin
      n_err++; $display("FAIL filtered_write: b count=%0d rd=%0d data=%h want 1/3/cc",
                        b_count, b_rd, b_data);
    end
    n_vec++;
    if (head !== q[0]) begin
      n_err++; $display("FAIL x0_third: got %h want %h", head, q[0]);
    end
    tick();
    cnt_tid = 2'd1; #1;
    n_vec++;
    if (cnt_value !== m_cnt[1] || b_cnt !== m_cnt[1] || trace_valid !== 1'b0) begin
      n_err++; $display("FAIL x0_cnt: got %0d/%0d valid=%b want %0d valid=0",
                        cnt_value, b_cnt, trace_valid, m_cnt[1]);
    end
  endtask

  task automatic test_overflow();
    trace_ready = 0;
    for (int i = 0; i < 20; i++) begin
      drive(2'(i % 4), 32'h100 + 32'(4 * i), 5'(i % 31 + 1), 1'b1, $urandom);
      tick();
    end
    retire_valid = 0;
    n_vec++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_count !== 32'd4 || m_drop != 4) begin
      n_err++; $display("FAIL overflow: count=%0d ovf=%b drop=%0d want 16/1/4",
                        fifo_count, overflow, drop_count);
    end
  endtask

  task automatic test_full_push_pop();
    trace_ready = 1;
    drive(2'd3, 32'h900, 5'd9, 1'b1, 32'hdead_beef);
    n_vec++;
    if (head !== q[0]) begin
      n_err++; $display("FAIL full_pp_head: got %h want %h", head, q[0]);
    end
    tick();
    retire_valid = 0; trace_ready = 0;
    n_vec++;
    if (fifo_count !== 5'd16 || drop_count !== 32'd4 || q[15].pc !== 32'h900) begin
      n_err++; $display("FAIL full_push_pop: count=%0d drop=%0d want 16/4", fifo_count, drop_count);
    end
  endtask

  task automatic test_drain();
    int popped = 0;
    trace_ready = 1; retire_valid = 0;
    for (int c = 0; c < 40 && (q.size() != 0 || trace_valid); c++) begin
      n_vec++;
      if (trace_valid !== (q.size() != 0)) begin
        n_err++; $display("FAIL drain_valid: got %b want %b", trace_valid, q.size() != 0);
      end else if (head !== q[0]) begin
        n_err++; $display("FAIL drain_head %0d: got %h want %h", popped, head, q[0]);
      end
      popped++;
      tick();
    end
    n_vec++;
    if (popped !== 16 || trace_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++; $display("FAIL drain_done: popped=%0d valid=%b ovf=%b want 16/0/1",
                        popped, trace_valid, overflow);
    end
  endtask

  task automatic test_clear();
    trace_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2'(i % 4), 32'h200 + 32'(4 * i), 5'd2, 1'b1, 32'(i));
      tick();
    end
    n_vec++;
    if (fifo_count !== 5'd5 || overflow !== 1'b1) begin
      n_err++; $display("FAIL pre_clear: count=%0d ovf=%b want 5/1", fifo_count, overflow);
    end
    drive(2'd2, 32'h300, 5'd4, 1'b1, 32'h77);
    clear = 1;
    tick();
    clear = 0; retire_valid = 0;
    n_vec++;
    if (fifo_count !== 0 || trace_valid !== 0 || overflow !== 0 || drop_count !== 0 ||
        b_count !== 0 || b_ovf !== 0) begin
      n_err++; $display("FAIL clear: count=%0d valid=%b ovf=%b drop=%0d want all 0",
                        fifo_count, trace_valid, overflow, drop_count);
    end
    for (int t = 0; t < 4; t++) begin
      cnt_tid = 2'(t); #1;
      n_vec++;
      if (cnt_value !== 0 || b_cnt !== 0) begin
        n_err++; $display("FAIL clear_cnt tid%0d: got %0d/%0d want 0", t, cnt_value, b_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    trace_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive(2'(i % 4), 32'h400 + 32'(4 * i), 5'd6, 1'b1, 32'h1000 + 32'(i));
      tick();
    end
    retire_valid = 0; trace_ready = 1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (head !== q[0]) begin
        n_err++; $display("FAIL pre_rst_head: got %h want %h", head, q[0]);
      end
      tick();
    end
    #2 rst = 1;
    #1;
    n_vec++;
    if (fifo_count !== 0 || trace_valid !== 0 || trace_data !== 0 || cnt_value !== 0) begin
      n_err++; $display("FAIL async_rst: count=%0d valid=%b data=%h cnt=%0d want 0",
                        fifo_count, trace_valid, trace_data, cnt_value);
    end
    @(posedge clk); #1;
    model_reset();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (trace_valid !== 0 || fifo_count !== 0) begin
      n_err++; $display("FAIL post_rst_idle: valid=%b count=%0d want 0", trace_valid, fifo_count);
    end
    drive(2'd2, 32'h500, 5'd8, 1'b1, 32'h5555);
    tick();
    retire_valid = 0;
    n_vec++;
    if (trace_valid !== 1'b1 || head !== q[0]) begin
      n_err++; $display("FAIL post_rst_capture: got %h want %h", head, q.size() ? q[0] : ent_t'(0));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_x0_filter();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_clear();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
